// File: rtl/nibble_serial_addsub_ctrl.sv
// ============================================================================
// Module   : nibble_serial_addsub_ctrl
// Brief    : Wide add/subtract sequenced through one 4-bit CLA slice, LSB
//            nibble first. Optional saturation with macro ADDSUB_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_addsub_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   sub,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   ovfl,
    output logic                   cout,
    output logic                   zero,
    output logic                   neg
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NIBBLES - 1);

    logic [1:0]       r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_acc;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;

    logic [3:0]       w_nib_a;
    logic [3:0]       w_nib_b;
    logic [3:0]       w_nib_s;
    logic             w_nib_cout;
    logic             w_slice_sub;
    logic [W-1:0]     w_raw;
    logic [W-1:0]     w_final;
    logic             w_ovfl;
    logic             w_last;

    assign w_nib_a     = r_a[{r_idx, 2'b00} +: 4];
    assign w_nib_b     = r_b[{r_idx, 2'b00} +: 4];
    // Inversion already applied when operands were latched; the slice only adds.
    assign w_slice_sub = 1'b0;

    always_comb begin : cla_slice
        logic [3:0] v_b;
        logic [3:0] v_p;
        logic [3:0] v_g;
        logic [4:0] v_c;
        v_b    = w_nib_b ^ {4{w_slice_sub}};
        v_p    = w_nib_a ^ v_b;
        v_g    = w_nib_a & v_b;
        v_c[0] = r_carry;
        v_c[1] = v_g[0] | (v_p[0] & v_c[0]);
        v_c[2] = v_g[1] | (v_p[1] & v_g[0]) | (v_p[1] & v_p[0] & v_c[0]);
        v_c[3] = v_g[2] | (v_p[2] & v_g[1]) | (v_p[2] & v_p[1] & v_g[0])
               | (v_p[2] & v_p[1] & v_p[0] & v_c[0]);
        v_c[4] = v_g[3] | (v_p[3] & v_g[2]) | (v_p[3] & v_p[2] & v_g[1])
               | (v_p[3] & v_p[2] & v_p[1] & v_g[0])
               | (v_p[3] & v_p[2] & v_p[1] & v_p[0] & v_c[0]);
        w_nib_s    = v_p ^ v_c[3:0];
        w_nib_cout = v_c[4];
    end

    always_comb begin
        w_raw = r_acc;
        w_raw[{r_idx, 2'b00} +: 4] = w_nib_s;
    end

    assign w_ovfl = (r_a[W-1] == r_b[W-1]) && (w_raw[W-1] != r_a[W-1]);
    assign w_last = (r_idx == c_last_idx);

`ifdef ADDSUB_SAT_EN
    always_comb begin
        w_final = w_raw;
        if (w_ovfl) begin
            w_final = r_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    assign w_final = w_raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            result  <= '0;
            ovfl    <= 1'b0;
            cout    <= 1'b0;
            zero    <= 1'b0;
            neg     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub;
                        r_idx   <= '0;
                        r_acc   <= '0;
                        r_state <= c_st_run;
                    end else begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_run: begin
                    r_acc   <= w_raw;
                    r_carry <= w_nib_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_state <= c_st_done;
                        result  <= w_final;
                        ovfl    <= w_ovfl;
                        cout    <= w_nib_cout;
                        zero    <= (w_final == '0);
                        neg     <= w_final[W-1];
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign busy = (r_state == c_st_run);
    assign done = (r_state == c_st_done);

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// ============================================================================
// Module   : tb_nibble_serial_addsub_ctrl
// Brief    : Scoreboard bench for nibble_serial_addsub_ctrl (NIBBLES=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_addsub_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    typedef struct packed {
        logic [W-1:0] res;
        logic         v;
        logic         c;
        logic         z;
        logic         n;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, ovfl, cout, zero, neg;
    logic [W-1:0] result;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    nibble_serial_addsub_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .ovfl(ovfl),
        .cout(cout), .zero(zero), .neg(neg)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic msub);
        exp_t         e;
        logic [W-1:0] be;
        logic [W:0]   full;
        be    = msub ? ~mb : mb;
        full  = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, msub};
        e.res = full[W-1:0];
        e.c   = full[W];
        e.v   = (ma[W-1] == be[W-1]) && (full[W-1] != ma[W-1]);
`ifdef ADDSUB_SAT_EN
        if (e.v) e.res = ma[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        e.z = (e.res == '0);
        e.n = e.res[W-1];
        return e;
    endfunction

    // Scoreboard: every done pulse retires the oldest expected completion.
    always @(negedge clk) begin
        if (rst_n && done) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done: got result=%h with empty queue", result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if ({result, ovfl, cout, zero, neg} !== e) begin
                    errors++;
                    $display("FAIL sb_result: got res=%h v=%b c=%b z=%b n=%b, want res=%h v=%b c=%b z=%b n=%b",
                             result, ovfl, cout, zero, neg, e.res, e.v, e.c, e.z, e.n);
                end
            end
        end
    end

    task automatic do_start(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic tsub, input bit push);
        @(negedge clk);
        a = ta; b = tb_; sub = tsub; start = 1'b1;
        if (push) sb_q.push_back(model(ta, tb_, tsub));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({busy, done, result, ovfl, cout, zero, neg} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b res=%h flags=%b%b%b%b, want all 0",
                     busy, done, result, ovfl, cout, zero, neg);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        do_start(16'h1234, 16'h0FCD, 1'b0, 1'b1);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL add_busy_cycle%0d: got busy=%b done=%b, want busy=1 done=0", k, busy, done);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL add_done_timing: got busy=%b done=%b, want busy=0 done=1", busy, done);
        end
        checks++;
        if ({result, ovfl, cout, zero, neg} !== {16'h2201, 4'b0000}) begin
            errors++;
            $display("FAIL add_value: got res=%h v=%b c=%b z=%b n=%b, want 2201 0000",
                     result, ovfl, cout, zero, neg);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL add_done_pulse: got done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_overflow;
        bit got;
        logic [W-1:0] want;
        do_start(16'h7FFF, 16'h0001, 1'b0, 1'b1);
        wait_done(N + 3, got);
`ifdef ADDSUB_SAT_EN
        want = 16'h7FFF;
`else
        want = 16'h8000;
`endif
        checks++;
        if (!got || result !== want || ovfl !== 1'b1 || cout !== 1'b0 || neg !== want[W-1]) begin
            errors++;
            $display("FAIL add_ovfl: got done=%b res=%h v=%b c=%b n=%b, want res=%h v=1 c=0 n=%b",
                     got, result, ovfl, cout, neg, want, want[W-1]);
        end
        do_start(16'h8000, 16'h0001, 1'b1, 1'b1);
        wait_done(N + 3, got);
`ifdef ADDSUB_SAT_EN
        want = 16'h8000;
`else
        want = 16'h7FFF;
`endif
        checks++;
        if (!got || result !== want || ovfl !== 1'b1 || neg !== want[W-1]) begin
            errors++;
            $display("FAIL sub_ovfl: got done=%b res=%h v=%b n=%b, want res=%h v=1 n=%b",
                     got, result, ovfl, neg, want, want[W-1]);
        end
    endtask

    task automatic test_sub;
        bit got;
        do_start(16'h0005, 16'h0005, 1'b1, 1'b1);
        wait_done(N + 3, got);
        checks++;
        if (!got || {result, ovfl, cout, zero, neg} !== {16'h0000, 4'b0110}) begin
            errors++;
            $display("FAIL sub_zero: got done=%b res=%h v=%b c=%b z=%b n=%b, want 0000 v0 c1 z1 n0",
                     got, result, ovfl, cout, zero, neg);
        end
        do_start(16'h0003, 16'h0005, 1'b1, 1'b1);
        wait_done(N + 3, got);
        checks++;
        if (!got || {result, ovfl, cout, zero, neg} !== {16'hFFFE, 4'b0001}) begin
            errors++;
            $display("FAIL sub_borrow: got done=%b res=%h v=%b c=%b z=%b n=%b, want fffe v0 c0 z0 n1",
                     got, result, ovfl, cout, zero, neg);
        end
    endtask

    task automatic test_back_to_back;
        do_start(16'h0001, 16'h0001, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        // Ignored request while the first operation is still running.
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || result !== 16'h0002) begin
            errors++;
            $display("FAIL b2b_first: got done=%b res=%h, want done=1 res=0002", done, result);
        end
        a = 16'h0010; b = 16'h0020; sub = 1'b0; start = 1'b1;
        sb_q.push_back(model(16'h0010, 16'h0020, 1'b0));
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL b2b_busy_cycle%0d: got busy=%b done=%b, want 1 0", k, busy, done);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || result !== 16'h0030) begin
            errors++;
            $display("FAIL b2b_second: got done=%b res=%h, want done=1 res=0030", done, result);
        end
    endtask

    task automatic test_async_reset;
        bit got;
        do_start(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, ovfl, cout, zero, neg} !== '0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b res=%h flags=%b%b%b%b, want all 0",
                     busy, done, result, ovfl, cout, zero, neg);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 2) @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL reset_abort: got done=%b busy=%b res=%h, want 0 0 0000", done, busy, result);
        end
        do_start(16'h0001, 16'h0002, 1'b0, 1'b1);
        wait_done(N + 3, got);
        checks++;
        if (!got || result !== 16'h0003) begin
            errors++;
            $display("FAIL post_reset: got done=%b res=%h, want done=1 res=0003", got, result);
        end
    endtask

    task automatic test_random;
        bit got;
        for (int i = 0; i < 20; i++) begin
            do_start(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            wait_done(N + 3, got);
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL rand_timeout: op %0d got no done, want done", i);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_add;
        test_overflow;
        test_sub;
        test_back_to_back;
        test_async_reset;
        test_random;
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
